// File: rtl/lights_out_button_frontend.sv
// Button front-end for the 3x3 lights-out game: synchronize, debounce and
// reduce nine raw push-button lines to one-hot single-cycle press pulses.
module lights_out_button_frontend #(
  parameter int N_BUTTONS       = 9,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_pulse,
  output logic                 multi_press,
  output logic                 held,
  output logic [7:0]           move_count
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_RELEASE
  } state_t;

  logic [N_BUTTONS-1:0] sy1, sy2, db;
  logic [CNT_W-1:0]     cnt [N_BUTTONS];

  state_t               state_q, state_d;
  logic [N_BUTTONS-1:0] pulse_d;
  logic                 multi_d;
  logic [7:0]           count_d;
  logic                 db_any, db_one_hot;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sy1 <= '0;
      sy2 <= '0;
    end else begin
      sy1 <= btn_raw;
      sy2 <= sy1;
    end
  end

  // NOTE: the counter array is reset explicitly; a leftover count after reset
  // could otherwise accept a press before a full stable interval elapses.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sy2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sy2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign db_any     = (db != '0);
  assign db_one_hot = db_any && ((db & (db - N_BUTTONS'(1))) == '0);

  // State register plus the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      btn_pulse   <= '0;
      multi_press <= 1'b0;
      move_count  <= '0;
    end else begin
      state_q     <= state_d;
      btn_pulse   <= pulse_d;
      multi_press <= multi_d;
      move_count  <= count_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (db_any)  state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!db_any) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    multi_d = 1'b0;
    count_d = move_count;
    if (state_q == IDLE && db_any) begin
      if (db_one_hot) begin
        pulse_d = db;
        if (move_count != 8'd255) count_d = move_count + 8'd1;
      end else begin
        multi_d = 1'b1;
      end
    end
  end

  assign held = (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_lights_out_button_frontend.sv
// Directed self-checking bench for lights_out_button_frontend with a short
// debounce interval so every timing boundary can be checked edge by edge.
module tb_lights_out_button_frontend;

  localparam int N   = 9;
  localparam int DB  = 4;
  // Input driven just after edge k is captured at k+1; pulse follows DB+2 later.
  localparam int LAT = DB + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_pulse;
  logic         multi_press;
  logic         held;
  logic [7:0]   move_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  lights_out_button_frontend #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_pulse  (btn_pulse),
    .multi_press(multi_press),
    .held       (held),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bump();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  // Drive a clean press, check the exact pulse edge, release and check held.
  task automatic press_release(input logic [N-1:0] b, input string tag);
    btn_raw = b;
    tick(LAT - 1);
    check({tag, "_early"}, 32'(btn_pulse), 32'h0);
    tick();
    bump();
    check({tag, "_pulse"}, 32'(btn_pulse), 32'(b));
    check({tag, "_count"}, 32'(move_count), 32'(exp_cnt));
    btn_raw = '0;
    tick(LAT);
    check({tag, "_rel"}, 32'(held), 32'h0);
  endtask

  initial begin
    logic [N-1:0] seen;
    rst     = 1'b1;
    btn_raw = '0;
    tick(3);
    rst = 1'b0;
    check("rst_pulse", 32'(btn_pulse), 32'h0);
    check("rst_multi", 32'(multi_press), 32'h0);
    check("rst_held",  32'(held), 32'h0);
    check("rst_count", 32'(move_count), 32'h0);
    tick(5);
    check("idle_pulse", 32'(btn_pulse), 32'h0);

    // Clean press
    btn_raw = 9'h010;
    tick(LAT - 1);
    check("clean_early", 32'(btn_pulse), 32'h0);
    check("clean_held0", 32'(held), 32'h0);
    tick();
    bump();
    check("clean_pulse", 32'(btn_pulse), 32'h010);
    check("clean_count", 32'(move_count), 32'(exp_cnt));
    check("clean_held",  32'(held), 32'h1);
    tick();
    check("clean_one",   32'(btn_pulse), 32'h0);
    check("clean_held2", 32'(held), 32'h1);
    btn_raw = '0;
    tick(LAT - 1);
    check("clean_rel_early", 32'(held), 32'h1);
    tick();
    check("clean_rel", 32'(held), 32'h0);

    // Bounce: high 2, low 1, then high; only the final rise completes
    btn_raw = 9'h001;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 2) btn_raw = 9'h000;
      if (t == 3) btn_raw = 9'h001;
      if (t == 10) bump();
      check("bounce_pulse", 32'(btn_pulse), (t == 10) ? 32'h001 : 32'h0);
    end
    check("bounce_count", 32'(move_count), 32'(exp_cnt));
    btn_raw = '0;
    tick(LAT);
    check("bounce_rel", 32'(held), 32'h0);

    // Chord
    btn_raw = 9'h003;
    tick(LAT);
    check("chord_multi", 32'(multi_press), 32'h1);
    check("chord_pulse", 32'(btn_pulse), 32'h0);
    check("chord_count", 32'(move_count), 32'(exp_cnt));
    check("chord_held",  32'(held), 32'h1);
    tick();
    check("chord_multi_one", 32'(multi_press), 32'h0);
    btn_raw = 9'h002;
    seen = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      seen |= btn_pulse;
      seen[0] |= multi_press;
    end
    check("chord_partial_quiet", 32'(seen), 32'h0);
    check("chord_partial_held",  32'(held), 32'h1);
    btn_raw = '0;
    tick(LAT);
    check("chord_rel", 32'(held), 32'h0);

    // Overlapping press: the first settled button wins
    btn_raw = 9'h004;
    tick(LAT);
    bump();
    check("ovl_pulse", 32'(btn_pulse), 32'h004);
    check("ovl_count", 32'(move_count), 32'(exp_cnt));
    tick(10 - LAT);
    btn_raw = 9'h024;
    seen = '0;
    for (int t = 0; t < 12; t++) begin
      tick();
      seen |= btn_pulse;
      seen[0] |= multi_press;
    end
    check("ovl_ignored", 32'(seen), 32'h0);
    check("ovl_held",    32'(held), 32'h1);
    btn_raw = '0;
    tick(LAT);
    check("ovl_rel", 32'(held), 32'h0);
    press_release(9'h020, "ovl_second");

    // Saturation
    for (int i = 0; i < 260; i++) press_release(N'(1) << (i % N), "sat");
    check("sat_final", 32'(move_count), 32'd255);

    // Reset mid-debounce with the button held
    btn_raw = 9'h001;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("rstmid_pulse", 32'(btn_pulse), 32'h0);
    check("rstmid_multi", 32'(multi_press), 32'h0);
    check("rstmid_held",  32'(held), 32'h0);
    check("rstmid_count", 32'(move_count), 32'h0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 7) bump();
      check("rstmid_wait", 32'(btn_pulse), (t == 7) ? 32'h001 : 32'h0);
    end
    check("rstmid_count1", 32'(move_count), 32'h1);

    // Reset while in WAIT_RELEASE: a held button counts as a fresh press
    tick(2);
    check("rstwr_held_pre", 32'(held), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("rstwr_held", 32'(held), 32'h0);
    check("rstwr_count", 32'(move_count), 32'h0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 7) bump();
      check("rstwr_wait", 32'(btn_pulse), (t == 7) ? 32'h001 : 32'h0);
    end
    check("rstwr_count1", 32'(move_count), 32'(exp_cnt));
    btn_raw = '0;
    tick(LAT);
    check("rstwr_rel", 32'(held), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
